// File: rtl/wb_scoreboard.sv
// Issue-stage scoreboard: per-register writeback countdowns drive RAW, WAW and
// write-port hazard detection for the instruction waiting in decode.
module wb_scoreboard #(
    parameter int NREG    = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 3,
    parameter int ALU_LAT = 3,
    parameter int MUL_LAT = 7,
    parameter int LD_LAT  = 4,
    parameter int ALU_RDY = 2,
    parameter int MUL_RDY = 1,
    parameter int LD_RDY  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    input  logic              issue_wr_en_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    input  logic [1:0]        issue_kind_i,
    input  logic              issue_use_rs1_i,
    input  logic [ADDR_W-1:0] issue_rs1_i,
    input  logic              issue_use_rs2_i,
    input  logic [ADDR_W-1:0] issue_rs2_i,
    input  logic              hold_i,
    output logic              issue_fire_o,
    output logic              stall_o,
    output logic              stall_raw_o,
    output logic              stall_waw_o,
    output logic              stall_port_o,
    output logic [NREG-1:0]   busy_vec_o
);

    // One extra bit so L+1 of the longest producer never aliases onto a small count.
    function automatic logic [CNT_W:0] lat_of(input logic [1:0] k);
        case (k)
            2'b01:   lat_of = (CNT_W+1)'(MUL_LAT);
            2'b10:   lat_of = (CNT_W+1)'(LD_LAT);
            default: lat_of = (CNT_W+1)'(ALU_LAT);
        endcase
    endfunction

    function automatic logic [CNT_W:0] rdy_of(input logic [1:0] k);
        case (k)
            2'b01:   rdy_of = (CNT_W+1)'(MUL_RDY);
            2'b10:   rdy_of = (CNT_W+1)'(LD_RDY);
            default: rdy_of = (CNT_W+1)'(ALU_RDY);
        endcase
    endfunction

    logic [NREG-1:0]  busy_reg;
    logic [NREG-1:0]  busy_next;
    logic [CNT_W-1:0] cnt_reg   [NREG];
    logic [CNT_W-1:0] cnt_next  [NREG];
    logic [1:0]       kind_reg  [NREG];
    logic [1:0]       kind_next [NREG];

    logic [NREG-1:0]  ready_vec;
    logic [NREG-1:0]  port_hit;
    logic [NREG-1:0]  write_sel;
    logic [CNT_W:0]   new_lat;
    logic             wr_req;
    logic             wr_fire;

    assign new_lat = lat_of(issue_kind_i);
    assign wr_req  = issue_valid_i & issue_wr_en_i & (issue_rd_i != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            assign ready_vec[gi] = (gi == 0) || !busy_reg[gi]
                                   || ({1'b0, cnt_reg[gi]} <= rdy_of(kind_reg[gi]));
            assign port_hit[gi]  = busy_reg[gi] && ({1'b0, cnt_reg[gi]} == new_lat + 1'b1);
            assign write_sel[gi] = wr_fire && (issue_rd_i == ADDR_W'(gi));

            // A WAW stall guarantees the target entry is idle when it is written.
            assign busy_next[gi] = hold_i        ? busy_reg[gi] :
                                   write_sel[gi] ? 1'b1 :
                                   (busy_reg[gi] && (cnt_reg[gi] != CNT_W'(1)));
            assign cnt_next[gi]  = hold_i        ? cnt_reg[gi] :
                                   write_sel[gi] ? new_lat[CNT_W-1:0] :
                                   busy_reg[gi]  ? cnt_reg[gi] - 1'b1 : cnt_reg[gi];
            assign kind_next[gi] = (!hold_i && write_sel[gi]) ? issue_kind_i : kind_reg[gi];
        end
    endgenerate

    assign stall_raw_o  = issue_valid_i
                          & ((issue_use_rs1_i & !ready_vec[issue_rs1_i])
                           | (issue_use_rs2_i & !ready_vec[issue_rs2_i]));
    assign stall_waw_o  = wr_req & busy_reg[issue_rd_i];
    assign stall_port_o = wr_req & (|port_hit);
    assign stall_o      = stall_raw_o | stall_waw_o | stall_port_o;
    assign issue_fire_o = issue_valid_i & !stall_o & !hold_i;
    assign wr_fire      = issue_fire_o & issue_wr_en_i & (issue_rd_i != '0);
    assign busy_vec_o   = busy_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_reg <= '0;
            cnt_reg  <= '{default: '0};
            kind_reg <= '{default: '0};
        end else begin
            busy_reg <= busy_next;
            cnt_reg  <= cnt_next;
            kind_reg <= kind_next;
        end
    end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed scenarios followed by random traffic, checked against a model that
// tracks each register's absolute writeback time on an unfrozen-cycle timeline.
module tb_wb_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_wr_en_i;
    logic [4:0]  issue_rd_i;
    logic [1:0]  issue_kind_i;
    logic        issue_use_rs1_i;
    logic [4:0]  issue_rs1_i;
    logic        issue_use_rs2_i;
    logic [4:0]  issue_rs2_i;
    logic        hold_i;
    logic        issue_fire_o;
    logic        stall_o;
    logic        stall_raw_o;
    logic        stall_waw_o;
    logic        stall_port_o;
    logic [31:0] busy_vec_o;

    wb_scoreboard dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .issue_valid_i   (issue_valid_i),
        .issue_wr_en_i   (issue_wr_en_i),
        .issue_rd_i      (issue_rd_i),
        .issue_kind_i    (issue_kind_i),
        .issue_use_rs1_i (issue_use_rs1_i),
        .issue_rs1_i     (issue_rs1_i),
        .issue_use_rs2_i (issue_use_rs2_i),
        .issue_rs2_i     (issue_rs2_i),
        .hold_i          (hold_i),
        .issue_fire_o    (issue_fire_o),
        .stall_o         (stall_o),
        .stall_raw_o     (stall_raw_o),
        .stall_waw_o     (stall_waw_o),
        .stall_port_o    (stall_port_o),
        .busy_vec_o      (busy_vec_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: now_t counts unfrozen edges since reset; a register is pending
    // while now_t < wb_t[r], with remaining count wb_t[r] - now_t.
    int         now_t;
    int         wb_t   [32];
    logic [1:0] kind_m [32];

    logic last_fire, last_raw, last_waw, last_port, last_stall;

    function automatic int lat_m(input logic [1:0] k);
        return (k == 2'b01) ? 7 : (k == 2'b10) ? 4 : 3;
    endfunction

    function automatic int rdy_m(input logic [1:0] k);
        return (k == 2'b01) ? 1 : (k == 2'b10) ? 1 : 2;
    endfunction

    function automatic bit pend_m(input int r);
        return (r != 0) && (wb_t[r] > now_t);
    endfunction

    function automatic bit src_ok_m(input int s);
        return !pend_m(s) || ((wb_t[s] - now_t) <= rdy_m(kind_m[s]));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic we, input int rd, input logic [1:0] k,
                         input logic u1, input int r1, input logic u2, input int r2,
                         input logic h);
        issue_valid_i   = v;
        issue_wr_en_i   = we;
        issue_rd_i      = 5'(rd);
        issue_kind_i    = k;
        issue_use_rs1_i = u1;
        issue_rs1_i     = 5'(r1);
        issue_use_rs2_i = u2;
        issue_rs2_i     = 5'(r2);
        hold_i          = h;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        bit e_raw, e_waw, e_port, e_stall, e_fire, wreq;
        logic [31:0] e_busy;
        int rd;
        @(negedge clk_i);
        rd     = int'(issue_rd_i);
        wreq   = issue_valid_i && issue_wr_en_i && (rd != 0);
        e_raw  = issue_valid_i && ((issue_use_rs1_i && !src_ok_m(int'(issue_rs1_i)))
                                || (issue_use_rs2_i && !src_ok_m(int'(issue_rs2_i))));
        e_waw  = wreq && pend_m(rd);
        e_port = 1'b0;
        e_busy = '0;
        for (int r = 1; r < 32; r++) begin
            if (pend_m(r)) begin
                e_busy[r] = 1'b1;
                if ((wb_t[r] - now_t) == lat_m(issue_kind_i) + 1) e_port = wreq;
            end
        end
        e_stall = e_raw || e_waw || e_port;
        e_fire  = issue_valid_i && !e_stall && !hold_i;
        check("busy_vec", busy_vec_o, e_busy);
        check("stall_raw", 32'(stall_raw_o), 32'(e_raw));
        check("stall_waw", 32'(stall_waw_o), 32'(e_waw));
        check("stall_port", 32'(stall_port_o), 32'(e_port));
        check("stall", 32'(stall_o), 32'(e_stall));
        check("fire", 32'(issue_fire_o), 32'(e_fire));
        last_fire  = issue_fire_o;
        last_raw   = stall_raw_o;
        last_waw   = stall_waw_o;
        last_port  = stall_port_o;
        last_stall = stall_o;
        if (e_fire)
            $display("issue t=%0t we=%0b rd=%0d kind=%0d rs1=%0d/%0b rs2=%0d/%0b",
                     $time, issue_wr_en_i, rd, issue_kind_i,
                     issue_rs1_i, issue_use_rs1_i, issue_rs2_i, issue_use_rs2_i);
        @(posedge clk_i);
        if (rst_i) begin
            now_t = 0;
            for (int r = 0; r < 32; r++) begin
                wb_t[r]   = 0;
                kind_m[r] = 2'b00;
            end
        end else if (!hold_i) begin
            if (e_fire && wreq) begin
                wb_t[rd]   = now_t + 1 + lat_m(issue_kind_i);
                kind_m[rd] = issue_kind_i;
            end
            now_t++;
        end
        #1;
    endtask

    // Hold one reader of src valid until it issues; returns cycles spent stalled.
    task automatic read_until_fire(input int src, output int stalls);
        stalls = 0;
        do begin
            drive(1'b1, 1'b0, 0, 2'b00, 1'b1, src, 1'b0, 0, 1'b0);
            tick();
            if (!last_fire) stalls++;
        end while (!last_fire && stalls < 20);
    endtask

    initial begin
        int n;
        now_t = 0;
        for (int r = 0; r < 32; r++) begin
            wb_t[r]   = 0;
            kind_m[r] = 2'b00;
        end
        rst_i = 1'b1;
        idle();
        tick();
        tick();
        rst_i = 1'b0;

        // ALU result is bypassable one cycle after issue (count 3 > 2, then 2).
        drive(1'b1, 1'b1, 5, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        read_until_fire(5, n);
        check("alu_raw_stalls", 32'(n), 32'd1);
        idle();
        repeat (4) tick();

        // Multiply: counts 7..2 stall a dependent reader, it issues at count 1.
        drive(1'b1, 1'b1, 7, 2'b01, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        read_until_fire(7, n);
        check("mul_raw_stalls", 32'(n), 32'd6);
        idle();
        repeat (3) tick();

        // ALU issued while the multiply sits at count 4 would share its writeback cycle.
        drive(1'b1, 1'b1, 7, 2'b01, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        idle();
        repeat (3) tick();
        drive(1'b1, 1'b1, 9, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        check("port_collide", 32'(last_port), 32'd1);
        tick();
        check("port_next_fire", 32'(last_fire), 32'd1);
        idle();
        repeat (8) tick();

        // Load under a 10-cycle freeze; countdown resumes afterwards.
        drive(1'b1, 1'b1, 3, 2'b10, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 10, 2'b00, 1'b1, 1, 1'b0, 0, 1'b1);
        repeat (10) tick();
        check("hold_no_fire", 32'(last_fire), 32'd0);
        check("hold_busy3", 32'(busy_vec_o[3]), 32'd1);
        idle();
        repeat (3) tick();
        check("ld_busy_after3", 32'(busy_vec_o[3]), 32'd1);
        tick();
        check("ld_busy_after4", 32'(busy_vec_o[3]), 32'd0);
        repeat (4) tick();

        // x0 is never tracked.
        drive(1'b1, 1'b1, 0, 2'b01, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 0, 2'b00, 1'b1, 0, 1'b1, 0, 1'b0);
        tick();
        check("x0_busy", busy_vec_o, 32'd0);
        check("x0_stall", 32'(last_stall), 32'd0);
        idle();
        tick();

        // WAW on x4 lasts until the old write retires.
        drive(1'b1, 1'b1, 4, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        n = 0;
        do begin
            drive(1'b1, 1'b1, 4, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
            tick();
            if (!last_fire) n++;
        end while (!last_fire && n < 20);
        check("waw_stalls", 32'(n), 32'd3);
        idle();
        repeat (4) tick();

        // Reset in the middle of a WAW stall clears everything on the next edge.
        drive(1'b1, 1'b1, 4, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        tick();
        check("waw_before_rst", 32'(last_waw), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rst_busy", busy_vec_o, 32'd0);
        tick();
        check("rst_waw_clear", 32'(last_waw), 32'd0);
        idle();
        tick();

        // Random traffic on a narrow register range to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                  int'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  1'($urandom), int'($urandom_range(0, 7)),
                  1'($urandom), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 7) == 0));
            tick();
        end
        rst_i = 1'b0;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
